// File: rtl/weight_buffer.sv
// Weight staging buffer: fetches a block of filter words from memory into local
// storage, then streams it to the PE NoC in one or more wrapping output passes.
module weight_buffer #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned MEM_W = 64,
   parameter int unsigned LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_load,
   input  logic [LEN_W-1:0] load_len,
   input  logic             start_output,
   input  logic [LEN_W-1:0] out_len,
   output logic             mem_req,
   input  logic             mem_ack,
   input  logic [MEM_W-1:0] mem_data,
   input  logic             mem_data_valid,
   output logic [MEM_W-1:0] weight_out_data,
   output logic             weight_out_valid,
   input  logic             weight_out_ready,
   output logic             weight_load_finish,
   output logic             weight_output_finish,
   output logic             overflow_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OUT_W = LEN_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_READY  = 2'd2,
      S_OUTPUT = 2'd3
   } state_e;

   state_e           state_q;
   logic             start_load_q;
   logic             start_output_q;
   logic [LEN_W-1:0] eff_len_q;
   logic [LEN_W-1:0] issued_q;
   logic [LEN_W-1:0] received_q;
   logic [LEN_W-1:0] remain_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [OUT_W-1:0] outstanding_q;
   logic [OUT_W-1:0] drop_q;
   logic [MEM_W-1:0] out_data_q;
   logic             out_valid_q;
   logic             load_fin_q;
   logic             out_fin_q;
   logic             ovf_q;
   logic [MEM_W-1:0] mem_q [DEPTH];

   logic             load_edge;
   logic             output_edge;
   logic             ack_fire;
   logic             data_acc;
   logic             drop_now;
   logic             wr_en;
   logic [LEN_W-1:0] eff_len_d;
   logic [LEN_W-1:0] rd_inc;
   logic [PTR_W-1:0] rd_nxt;
   logic [OUT_W-1:0] outstanding_d;

   assign mem_req = (state_q == S_LOAD) && (issued_q < eff_len_q);

   // Response bookkeeping: responses are in order, so the oldest `drop_q` returns
   // belong to an aborted load and are discarded.
   always_comb begin
      load_edge     = start_load & ~start_load_q;
      output_edge   = start_output & ~start_output_q;
      eff_len_d     = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
      ack_fire      = mem_ack & mem_req;
      data_acc      = mem_data_valid & ((outstanding_q != '0) | ack_fire);
      drop_now      = data_acc & (drop_q != '0);
      wr_en         = data_acc & ~drop_now & (state_q == S_LOAD) & ~load_edge;
      outstanding_d = outstanding_q + OUT_W'(ack_fire) - OUT_W'(data_acc);
      rd_inc        = LEN_W'(rd_ptr_q) + LEN_W'(1);
      rd_nxt        = (rd_inc >= eff_len_q) ? '0 : PTR_W'(rd_inc);
   end

   // Storage carries no reset; its contents are meaningless until a load fills it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         start_load_q   <= 1'b0;
         start_output_q <= 1'b0;
         eff_len_q      <= '0;
         issued_q       <= '0;
         received_q     <= '0;
         remain_q       <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         outstanding_q  <= '0;
         drop_q         <= '0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         load_fin_q     <= 1'b0;
         out_fin_q      <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         start_load_q   <= start_load;
         start_output_q <= start_output;
         outstanding_q  <= outstanding_d;
         load_fin_q     <= 1'b0;
         out_fin_q      <= 1'b0;

         if (mem_data_valid && !data_acc) begin
            ovf_q <= 1'b1;
         end
         if (drop_now) begin
            drop_q <= drop_q - OUT_W'(1);
         end
         if (ack_fire) begin
            issued_q <= issued_q + LEN_W'(1);
         end

         // A load edge restarts from any state; in-flight responses become drops.
         if (load_edge) begin
            eff_len_q   <= eff_len_d;
            issued_q    <= '0;
            received_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= outstanding_d;
            out_valid_q <= 1'b0;
            if (eff_len_d == '0) begin
               load_fin_q <= 1'b1;
               state_q    <= S_READY;
            end else begin
               state_q    <= S_LOAD;
            end
         end else begin
            unique case (state_q)
               S_IDLE: begin
               end
               S_LOAD: begin
                  if (wr_en) begin
                     wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                     received_q <= received_q + LEN_W'(1);
                     if ((received_q + LEN_W'(1)) == eff_len_q) begin
                        load_fin_q <= 1'b1;
                        state_q    <= S_READY;
                     end
                  end
               end
               S_READY: begin
                  if (output_edge) begin
                     remain_q <= out_len;
                     if (out_len == '0) begin
                        out_fin_q <= 1'b1;
                     end else begin
                        state_q   <= S_OUTPUT;
                     end
                  end
               end
               S_OUTPUT: begin
                  // First cycle primes the output register; later transfers prefetch
                  // the following word so a ready NoC sees one word per cycle.
                  if (!out_valid_q) begin
                     out_data_q  <= mem_q[rd_ptr_q];
                     out_valid_q <= 1'b1;
                  end else if (weight_out_ready) begin
                     rd_ptr_q <= rd_nxt;
                     remain_q <= remain_q - LEN_W'(1);
                     if (remain_q == LEN_W'(1)) begin
                        out_valid_q <= 1'b0;
                        out_fin_q   <= 1'b1;
                        state_q     <= S_READY;
                     end else begin
                        out_data_q  <= mem_q[rd_nxt];
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign weight_out_data      = out_data_q;
   assign weight_out_valid     = out_valid_q;
   assign weight_load_finish   = load_fin_q;
   assign weight_output_finish = out_fin_q;
   assign overflow_err         = ovf_q;

endmodule

// File: tb/tb_weight_buffer.sv
// Bench for weight_buffer: randomized memory responder and NoC sink, with the
// expected buffer contents rebuilt from the words acknowledged after each load edge.
module tb_weight_buffer;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned MEM_W = 64;
   localparam int unsigned LEN_W = 6;

   logic             clk;
   logic             rst_n;
   logic             start_load;
   logic [LEN_W-1:0] load_len;
   logic             start_output;
   logic [LEN_W-1:0] out_len;
   logic             mem_req;
   logic             mem_ack;
   logic [MEM_W-1:0] mem_data;
   logic             mem_data_valid;
   logic [MEM_W-1:0] weight_out_data;
   logic             weight_out_valid;
   logic             weight_out_ready;
   logic             weight_load_finish;
   logic             weight_output_finish;
   logic             overflow_err;

   weight_buffer #(.DEPTH(DEPTH), .MEM_W(MEM_W), .LEN_W(LEN_W)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start_load           (start_load),
      .load_len             (load_len),
      .start_output         (start_output),
      .out_len              (out_len),
      .mem_req              (mem_req),
      .mem_ack              (mem_ack),
      .mem_data             (mem_data),
      .mem_data_valid       (mem_data_valid),
      .weight_out_data      (weight_out_data),
      .weight_out_valid     (weight_out_valid),
      .weight_out_ready     (weight_out_ready),
      .weight_load_finish   (weight_load_finish),
      .weight_output_finish (weight_output_finish),
      .overflow_err         (overflow_err)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Responder configuration and state.
   int               ack_budget = 0;
   bit               ack_rand = 0;
   int               lat_max = 0;
   bit               hold = 0;
   bit               stray = 0;
   bit               rdy_def = 1;
   bit               rdy_q[$];
   logic [MEM_W-1:0] pend_data[$];
   int               pend_due[$];
   logic [MEM_W-1:0] log_data[$];
   int               log_idx[$];

   // Monitor results.
   int               n_lfin, lfin_cyc, n_ofin, ofin_cyc, n_req_cyc, n_val_cyc, n_stall;
   int               first_val_cyc, last_xfer_cyc, n_unstable;
   bit               prev_hold = 0;
   logic [MEM_W-1:0] prev_data;
   logic [MEM_W-1:0] out_q[$];

   // Reference model of the buffer.
   logic [MEM_W-1:0] exp_mem[$];
   int               model_eff = 0;
   int               model_rd = 0;
   int               edge_idx, oedge;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder and NoC ready driver; words are tagged with the posedge
   // index at which their ack is sampled.
   initial begin : responder
      logic [MEM_W-1:0] w;
      int               due;
      mem_ack = 1'b0;
      mem_data_valid = 1'b0;
      mem_data = '0;
      weight_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req && ack_budget > 0 && (!ack_rand || $urandom_range(0, 2) != 0)) begin
            mem_ack = 1'b1;
            ack_budget--;
            w = {$urandom, $urandom};
            due = cyc + 1 + int'($urandom_range(0, lat_max));
            if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
            pend_data.push_back(w);
            pend_due.push_back(due);
            log_data.push_back(w);
            log_idx.push_back(cyc + 1);
         end
         mem_data_valid = 1'b0;
         if (stray) begin
            stray = 0;
            mem_data_valid = 1'b1;
            mem_data = {$urandom, $urandom};
         end else if (!hold && pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
            mem_data_valid = 1'b1;
            mem_data = pend_data.pop_front();
            void'(pend_due.pop_front());
         end
         weight_out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : rdy_def;
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      if (weight_load_finish) begin n_lfin++; lfin_cyc = cyc; end
      if (weight_output_finish) begin n_ofin++; ofin_cyc = cyc; end
      if (mem_req) n_req_cyc++;
      if (weight_out_valid) begin
         n_val_cyc++;
         if (first_val_cyc < 0) first_val_cyc = cyc;
         if (!weight_out_ready) n_stall++;
      end
      if (prev_hold && weight_out_valid && weight_out_data !== prev_data) n_unstable++;
      if (weight_out_valid && weight_out_ready) begin
         out_q.push_back(weight_out_data);
         last_xfer_cyc = cyc;
      end
      prev_hold = weight_out_valid && !weight_out_ready;
      prev_data = weight_out_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic nc();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_mon();
      n_lfin = 0; n_ofin = 0; n_req_cyc = 0; n_val_cyc = 0; n_stall = 0;
      first_val_cyc = -1; last_xfer_cyc = -1; n_unstable = 0;
      lfin_cyc = -1; ofin_cyc = -1;
      out_q.delete();
   endtask

   task automatic do_load(input int len, input string name);
      int exp_n;
      clear_mon();
      log_data.delete();
      log_idx.delete();
      load_len = LEN_W'(len);
      start_load = 1'b1;
      edge_idx = cyc + 1;
      nc();
      start_load = 1'b0;
      for (int i = 0; i < 800 && n_lfin == 0; i++) nc();
      nc();
      nc();
      exp_n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
      exp_mem.delete();
      foreach (log_idx[i]) if (log_idx[i] > edge_idx) exp_mem.push_back(log_data[i]);
      n_cmp++;
      if (n_lfin !== 1) begin
         n_fail++;
         $display("FAIL %s load_finish_pulses: got %0d expected 1", name, n_lfin);
      end
      n_cmp++;
      if (exp_mem.size() != exp_n) begin
         n_fail++;
         $display("FAIL %s acked_requests: got %0d expected %0d", name, exp_mem.size(), exp_n);
      end
      model_eff = exp_n;
      model_rd = 0;
   endtask

   task automatic do_pass(input int len, input bit bp, input string name);
      int           n;
      logic [MEM_W-1:0] exp;
      clear_mon();
      out_len = LEN_W'(len);
      start_output = 1'b1;
      oedge = cyc + 1;
      nc();
      start_output = 1'b0;
      if (bp) begin
         rdy_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      end
      for (int i = 0; i < 800 && n_ofin == 0; i++) nc();
      nc();
      nc();
      n_cmp++;
      if (n_ofin !== 1) begin
         n_fail++;
         $display("FAIL %s output_finish_pulses: got %0d expected 1", name, n_ofin);
      end
      n_cmp++;
      if (out_q.size() != len) begin
         n_fail++;
         $display("FAIL %s words_out: got %0d expected %0d", name, out_q.size(), len);
      end
      n = (out_q.size() < len) ? out_q.size() : len;
      for (int i = 0; i < n; i++) begin
         exp = exp_mem[(model_rd + i) % model_eff];
         n_cmp++;
         if (out_q[i] !== exp) begin
            n_fail++;
            $display("FAIL %s word[%0d]: got %h expected %h", name, i, out_q[i], exp);
         end
      end
      n_cmp++;
      if (n_val_cyc - n_stall != len) begin
         n_fail++;
         $display("FAIL %s ready_valid_cycles: got %0d expected %0d", name, n_val_cyc - n_stall, len);
      end
      n_cmp++;
      if (n_unstable != 0) begin
         n_fail++;
         $display("FAIL %s data_stable_under_stall: got %0d changes expected 0", name, n_unstable);
      end
      if (len > 0) begin
         n_cmp++;
         if (first_val_cyc - oedge != 1) begin
            n_fail++;
            $display("FAIL %s first_valid_latency: got %0d expected 1", name, first_val_cyc - oedge);
         end
         n_cmp++;
         if (ofin_cyc != last_xfer_cyc + 1) begin
            n_fail++;
            $display("FAIL %s finish_after_last: got %0d expected %0d", name, ofin_cyc, last_xfer_cyc + 1);
         end
         model_rd = (model_rd + len) % model_eff;
      end else begin
         n_cmp++;
         if (ofin_cyc - oedge != 0) begin
            n_fail++;
            $display("FAIL %s zero_len_finish_latency: got %0d expected 0", name, ofin_cyc - oedge);
         end
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({mem_req, weight_out_valid, weight_load_finish, weight_output_finish, overflow_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl_outputs: got %b expected 00000",
                  {mem_req, weight_out_valid, weight_load_finish, weight_output_finish, overflow_err});
      end
      n_cmp++;
      if (weight_out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_out_data: got %h expected 0", weight_out_data);
      end
      rst_n = 1'b1;
      nc();
      clear_mon();
      out_len = LEN_W'(4);
      start_output = 1'b1;
      nc();
      start_output = 1'b0;
      repeat (4) nc();
      n_cmp++;
      if (n_val_cyc != 0 || n_ofin != 0) begin
         n_fail++;
         $display("FAIL idle_output_ignored: got valid=%0d finish=%0d expected 0 0", n_val_cyc, n_ofin);
      end
      n_cmp++;
      if (n_req_cyc != 0) begin
         n_fail++;
         $display("FAIL idle_no_req: got %0d expected 0", n_req_cyc);
      end
   endtask

   task automatic test_load_zero_latency();
      ack_rand = 0; lat_max = 0; ack_budget = 100000;
      do_load(8, "zero_lat");
      n_cmp++;
      if (lfin_cyc - edge_idx != 8) begin
         n_fail++;
         $display("FAIL zero_lat finish_latency: got %0d expected 8", lfin_cyc - edge_idx);
      end
      n_cmp++;
      if (n_req_cyc != 8) begin
         n_fail++;
         $display("FAIL zero_lat req_cycles: got %0d expected 8", n_req_cyc);
      end
      do_pass(8, 0, "zero_lat_pass");
   endtask

   task automatic test_load_random();
      ack_rand = 1; lat_max = 4;
      do_load(32, "rand_lat");
      n_cmp++;
      if (overflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_lat overflow: got %b expected 0", overflow_err);
      end
      do_pass(32, 0, "rand_lat_pass");
   endtask

   task automatic test_wrap_multipass();
      ack_rand = 1; lat_max = 2;
      do_load(5, "wrap");
      do_pass(3, 0, "wrap_pass1");
      do_pass(3, 0, "wrap_pass2");
   endtask

   task automatic test_backpressure();
      ack_rand = 1; lat_max = 3;
      do_load(12, "bp");
      do_pass(12, 1, "bp_pass");
   endtask

   task automatic test_boundaries();
      ack_rand = 0; lat_max = 1;
      do_load(0, "len0");
      n_cmp++;
      if (n_req_cyc != 0) begin
         n_fail++;
         $display("FAIL len0 req_cycles: got %0d expected 0", n_req_cyc);
      end
      n_cmp++;
      if (lfin_cyc - edge_idx != 0) begin
         n_fail++;
         $display("FAIL len0 finish_latency: got %0d expected 0", lfin_cyc - edge_idx);
      end
      do_pass(0, 0, "out0");
      n_cmp++;
      if (n_val_cyc != 0) begin
         n_fail++;
         $display("FAIL out0 valid_cycles: got %0d expected 0", n_val_cyc);
      end
      ack_rand = 1;
      do_load(40, "clamp40");
      do_pass(32, 0, "clamp40_pass");
   endtask

   task automatic test_abort();
      ack_rand = 0; lat_max = 0; hold = 1; ack_budget = 2;
      clear_mon();
      log_data.delete();
      log_idx.delete();
      load_len = LEN_W'(8);
      start_load = 1'b1;
      nc();
      start_load = 1'b0;
      repeat (4) nc();
      n_cmp++;
      if (log_idx.size() != 2 || n_lfin != 0) begin
         n_fail++;
         $display("FAIL abort_setup: got acks=%0d finish=%0d expected 2 0", log_idx.size(), n_lfin);
      end
      ack_budget = 100000;
      hold = 0;
      do_load(6, "abort_reload");
      n_cmp++;
      if (overflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL abort overflow: got %b expected 0", overflow_err);
      end
      do_pass(6, 0, "abort_pass");
   endtask

   task automatic test_overflow();
      stray = 1;
      nc();
      nc();
      n_cmp++;
      if (overflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_overflow: got %b expected 1", overflow_err);
      end
      repeat (3) nc();
      n_cmp++;
      if (overflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky: got %b expected 1", overflow_err);
      end
      do_pass(6, 0, "after_stray_pass");
   endtask

   task automatic test_reset_mid_output();
      rdy_def = 0;
      clear_mon();
      out_len = LEN_W'(4);
      start_output = 1'b1;
      nc();
      start_output = 1'b0;
      nc();
      nc();
      n_cmp++;
      if (weight_out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midout_valid_before_reset: got %b expected 1", weight_out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_req, weight_out_valid, weight_load_finish, weight_output_finish, overflow_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL midout_reset_ctrl: got %b expected 00000",
                  {mem_req, weight_out_valid, weight_load_finish, weight_output_finish, overflow_err});
      end
      n_cmp++;
      if (weight_out_data !== '0) begin
         n_fail++;
         $display("FAIL midout_reset_data: got %h expected 0", weight_out_data);
      end
      nc();
      rst_n = 1'b1;
      rdy_def = 1;
      nc();
      ack_rand = 1; lat_max = 2;
      do_load(4, "post_reset");
      do_pass(4, 0, "post_reset_pass");
   endtask

   initial begin
      rst_n = 1'b1;
      start_load = 1'b0;
      load_len = '0;
      start_output = 1'b0;
      out_len = '0;
      #1;
      rst_n = 1'b0;
      repeat (2) nc();
      test_reset();
      test_load_zero_latency();
      test_load_random();
      test_wrap_multipass();
      test_backpressure();
      test_boundaries();
      test_abort();
      test_overflow();
      test_reset_mid_output();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_buffer.md
# weight_buffer

Weight staging buffer between the memory arbitration logic and the PE array. It fetches a block of filter words from external memory through the controller's request/ack/data port and holds them in on-chip storage. It then streams them to the PE NoC in one or more output passes, one per filter-load phase. It reports `weight_load_finish` and `weight_output_finish` back to the controller FSM.

## Interface
- `DEPTH`, 32, storage depth in memory words (power of two)
- `MEM_W`, 64, memory word width in bits
- `LEN_W`, 6, width of length inputs; equals $clog2(DEPTH)+1
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_load`  in  1  level from controller; a rising edge starts a load
- `load_len`  in  LEN_W  words to fetch; sampled on the `start_load` rising edge
- `start_output`  in  1  level from controller; a rising edge starts an output pass
- `out_len`  in  LEN_W  words per pass; sampled on the `start_output` rising edge
- `mem_req`  out  1  request one memory word
- `mem_ack`  in  1  request accepted this cycle
- `mem_data`  in  MEM_W  returned memory word
- `mem_data_valid`  in  1  `mem_data` valid this cycle
- `weight_out_data`  out  MEM_W  word to the NoC
- `weight_out_valid`  out  1  `weight_out_data` valid
- `weight_out_ready`  in  1  NoC accepts the word
- `weight_load_finish`  out  1  one-cycle pulse when the load completes
- `weight_output_finish`  out  1  one-cycle pulse when a pass completes
- `overflow_err`  out  1  sticky; set by `mem_data_valid` with nothing outstanding

## Operation
- FSM has four states:
  - IDLE: reached after reset; waits for a load.
  - LOAD: fetching words from memory.
  - READY: buffer holds valid weights; waits for a pass or a new load.
  - OUTPUT: streaming a pass to the NoC.
- Edge detection: a registered copy of each start level. A start counts only when the level is 1 and its registered copy is 0.
- IDLE/READY, `start_load` edge -> LOAD:
  - `eff_len = min(load_len, DEPTH)`.
  - Reset `issued`, `received`, `wr_ptr` and `rd_ptr` to 0.
- LOAD:
  - `mem_req = (issued < eff_len)`.
  - Each cycle with `mem_ack & mem_req` increments `issued`.
  - Each `mem_data_valid` writes `mem_data` to `mem[wr_ptr]`, then increments `wr_ptr` and `received`.
  - Data returns in order, zero or more cycles after ack; data in the same cycle as its ack is legal.
  - When `received` reaches `eff_len`: pulse `weight_load_finish` and go to READY.
- `eff_len == 0`: no `mem_req`; finish pulse in the cycle after the edge.
- READY, `start_output` edge -> OUTPUT; `remain = out_len`.
- OUTPUT:
  - Reads `mem[rd_ptr]` into an output register.
  - Handshake: a word transfers on `valid & ready`.
  - Per transfer, `rd_ptr` advances, wrapping to 0 when it reaches `eff_len`; `remain` decrements.
  - The next word is prefetched so back-to-back transfers sustain 1 word/cycle.
  - After the transfer with `remain == 1`: pulse `weight_output_finish`, return to READY, keep `rd_ptr`. The next pass continues from the next word.
- `out_len == 0`: no valid; finish pulse in the cycle after the edge.
- A `start_load` edge in LOAD/OUTPUT aborts the operation and restarts LOAD:
  - Drop `weight_out_valid`.
  - Responses still outstanding from the aborted load are discarded. An `outstanding = issued - received` counter tracks them; it is carried over and its data is dropped.
- A `start_output` edge outside READY is ignored.
- `mem_data_valid` with nothing outstanding and no accepted ack this cycle sets `overflow_err` and writes nothing.

## Timing
- Reset values:
  - State IDLE.
  - All counters and pointers 0.
  - `mem_req`, `weight_out_valid`, both finish pulses and `overflow_err` = 0.
  - `weight_out_data` = 0.
- `mem_req` is combinational from state/`issued`; it rises the cycle after the `start_load` edge.
- `weight_load_finish` is registered: high the cycle after the last `mem_data_valid`.
- First `weight_out_valid`: 2 cycles after the `start_output` edge (1 to enter OUTPUT, 1 for the registered read).
- `weight_out_data` is stable while `valid & !ready`.
- `weight_output_finish` is high the cycle after the final handshake, coincident with state READY.
- Async reset mid-LOAD/OUTPUT returns all outputs to reset values immediately. Memory contents become don't-care.

## Test plan
- Load, zero latency: `load_len=8`, ack every cycle, data valid same cycle (D0..D7). Required:
  - 8 acked requests.
  - `weight_load_finish` on cycle 9 after the edge.
  - `mem[0..7]` = D0..D7.
- Load, random latency and gaps: `load_len=32`, ack gaps and 0-4 cycle return latency. Required: exactly 32 requests, data stored in order, no `overflow_err`.
- Wrapped multi-pass output: `load_len=5`, passes with `out_len=3` twice. Required:
  - Pass 1 outputs D0,D1,D2; pass 2 outputs D3,D4,D0.
  - One finish pulse per pass.
- Output backpressure: `weight_out_ready` toggled 1,0,0,1 during a pass. Required: data held while not ready, no duplicated or skipped words, sustained 1/cycle when ready.
- Boundaries: `load_len=0` and `out_len=0` each give a single finish pulse with no req/valid; `load_len=40` is clamped to 32 requests.
- Abort and errors:
  - `start_load` re-edge mid-LOAD with 2 responses outstanding: those 2 are discarded and the new load fills from `wr_ptr=0`.
  - A stray `mem_data_valid` in READY sets `overflow_err`.
  - `rst_n` low mid-OUTPUT clears valid in the same cycle.
